gnss_clock_scheduler: RTL and testbench

//  Runtime-programmable replacement for the fixed GLONASS/GPS clock divider.

---
 rtl/gnss_clock_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_gnss_clock_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gnss_clock_scheduler.sv
// GNSS clock scheduler: GLONASS/GPS clock dividers with runtime-programmable divisors
// applied at period boundaries, plus a round-robin arbiter for the shared sample-event port.
module gnss_clock_scheduler #(
    parameter int unsigned CNT_W        = 28,
    parameter int unsigned DIV_GLO_INIT = 25,
    parameter int unsigned DIV_GPS_INIT = 50,
    parameter int unsigned MIN_DIV      = 2
) (
    input  logic             in_clock,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_sel,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_err,
    output logic             out_clock_GLONASS,
    output logic             out_clock_GPS,
    output logic             tick_GLONASS,
    output logic             tick_GPS,
    output logic             smp_valid,
    output logic             smp_sel
);
    localparam logic [0:0] S_IDLE      = 1'b0;
    localparam logic [0:0] S_WAIT_WRAP = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt_glo;
    logic [CNT_W-1:0] r_cnt_gps;
    logic [CNT_W-1:0] r_div_glo;
    logic [CNT_W-1:0] r_div_gps;
    logic [CNT_W-1:0] r_lat_div;
    logic             r_lat_sel;
    logic             r_cfg_ready;
    logic             r_cfg_err;
    logic             r_out_glo;
    logic             r_out_gps;
    logic             r_tick_glo;
    logic             r_tick_gps;
    logic             r_smp_valid;
    logic             r_smp_sel;
    logic             r_pend_glo;
    logic             r_pend_gps;
    logic             r_rr;

    logic w_wrap_glo;
    logic w_wrap_gps;
    logic w_accept;
    logic w_reject;
    logic w_apply_glo;
    logic w_apply_gps;
    logic w_req_glo;
    logic w_req_gps;
    logic w_grant_vld;
    logic w_grant_sel;
    logic w_pend_glo_nxt;
    logic w_pend_gps_nxt;
    logic w_rr_nxt;

    assign w_wrap_glo = (r_cnt_glo == r_div_glo - CNT_W'(1));
    assign w_wrap_gps = (r_cnt_gps == r_div_gps - CNT_W'(1));

    // Config FSM: a divisor swap only lands on a wrap strictly after the accept cycle
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_apply_glo = 1'b0;
        w_apply_gps = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_cfg_ready && cfg_valid) begin
                    if (cfg_div < CNT_W'(MIN_DIV)) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_WAIT_WRAP;
                    end
                end
            end
            S_WAIT_WRAP: begin
                w_apply_glo = !r_lat_sel && w_wrap_glo;
                w_apply_gps = r_lat_sel && w_wrap_gps;
                if (w_apply_glo || w_apply_gps) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge in_clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cfg_ready <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_lat_sel   <= 1'b0;
            r_lat_div   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cfg_ready <= (w_state_nxt == S_IDLE);
            r_cfg_err   <= w_reject;
            if (w_accept) begin
                r_lat_sel <= cfg_sel;
                r_lat_div <= cfg_div;
            end
        end
    end

    // Divider channels; divisor only changes as the counter returns to zero
    always_ff @(posedge in_clock or posedge reset) begin
        if (reset) begin
            r_cnt_glo  <= '0;
            r_cnt_gps  <= '0;
            r_div_glo  <= CNT_W'(DIV_GLO_INIT);
            r_div_gps  <= CNT_W'(DIV_GPS_INIT);
            r_out_glo  <= 1'b0;
            r_out_gps  <= 1'b0;
            r_tick_glo <= 1'b0;
            r_tick_gps <= 1'b0;
        end else begin
            r_cnt_glo  <= w_wrap_glo ? '0 : r_cnt_glo + CNT_W'(1);
            r_cnt_gps  <= w_wrap_gps ? '0 : r_cnt_gps + CNT_W'(1);
            if (w_apply_glo) r_div_glo <= r_lat_div;
            if (w_apply_gps) r_div_gps <= r_lat_div;
            r_out_glo  <= (r_cnt_glo < (r_div_glo >> 1));
            r_out_gps  <= (r_cnt_gps < (r_div_gps >> 1));
            r_tick_glo <= w_wrap_glo;
            r_tick_gps <= w_wrap_gps;
        end
    end

    assign w_req_glo = r_tick_glo | r_pend_glo;
    assign w_req_gps = r_tick_gps | r_pend_gps;

    // Arbiter: deferred requests first, otherwise round-robin on contention
    always_comb begin
        w_grant_vld    = 1'b0;
        w_grant_sel    = 1'b0;
        w_pend_glo_nxt = r_pend_glo;
        w_pend_gps_nxt = r_pend_gps;
        w_rr_nxt       = r_rr;
        if (w_req_glo && w_req_gps) begin
            w_grant_vld = 1'b1;
            if (r_pend_glo && !r_pend_gps) begin
                w_grant_sel = 1'b0;
            end else if (r_pend_gps && !r_pend_glo) begin
                w_grant_sel = 1'b1;
            end else begin
                w_grant_sel = r_rr;
                w_rr_nxt    = ~r_rr;
            end
            w_pend_glo_nxt = w_grant_sel;
            w_pend_gps_nxt = ~w_grant_sel;
        end else if (w_req_glo) begin
            w_grant_vld    = 1'b1;
            w_pend_glo_nxt = 1'b0;
        end else if (w_req_gps) begin
            w_grant_vld    = 1'b1;
            w_grant_sel    = 1'b1;
            w_pend_gps_nxt = 1'b0;
        end
    end

    always_ff @(posedge in_clock or posedge reset) begin
        if (reset) begin
            r_smp_valid <= 1'b0;
            r_smp_sel   <= 1'b0;
            r_pend_glo  <= 1'b0;
            r_pend_gps  <= 1'b0;
            r_rr        <= 1'b0;
        end else begin
            r_smp_valid <= w_grant_vld;
            r_smp_sel   <= w_grant_sel;
            r_pend_glo  <= w_pend_glo_nxt;
            r_pend_gps  <= w_pend_gps_nxt;
            r_rr        <= w_rr_nxt;
        end
    end

    assign cfg_ready         = r_cfg_ready;
    assign cfg_err           = r_cfg_err;
    assign out_clock_GLONASS = r_out_glo;
    assign out_clock_GPS     = r_out_gps;
    assign tick_GLONASS      = r_tick_glo;
    assign tick_GPS          = r_tick_gps;
    assign smp_valid         = r_smp_valid;
    assign smp_sel           = r_smp_sel;

endmodule

// File: tb/tb_gnss_clock_scheduler.sv
// Bench for gnss_clock_scheduler: period-level reference model with a sample-event
// scoreboard, a vector table for the post-reset run, and hand sequences for config corners.
module tb_gnss_clock_scheduler;
    localparam int unsigned CNT_W = 28;

    logic             in_clock = 1'b0;
    logic             reset;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_sel;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_err;
    logic             out_clock_GLONASS;
    logic             out_clock_GPS;
    logic             tick_GLONASS;
    logic             tick_GPS;
    logic             smp_valid;
    logic             smp_sel;

    gnss_clock_scheduler #(
        .CNT_W(CNT_W), .DIV_GLO_INIT(25), .DIV_GPS_INIT(50), .MIN_DIV(2)
    ) u_dut (
        .in_clock(in_clock), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
        .cfg_div(cfg_div), .cfg_err(cfg_err),
        .out_clock_GLONASS(out_clock_GLONASS), .out_clock_GPS(out_clock_GPS),
        .tick_GLONASS(tick_GLONASS), .tick_GPS(tick_GPS),
        .smp_valid(smp_valid), .smp_sel(smp_sel)
    );

    always #5 in_clock = ~in_clock;

    typedef struct {
        int   cyc;
        logic sel;
    } smp_t;

    // exp bits: tick_GLO, tick_GPS, out_GLO, out_GPS, smp_valid, smp_sel
    typedef struct {
        int         cyc;
        logic [5:0] exp;
    } vec_t;

    int   n_chk;
    int   n_err;
    int   cyc;
    int   m_last[2];
    int   m_per[2];
    int   m_next[2];
    int   m_new_per;
    int   m_new_sel;
    int   m_acc_edge;
    logic m_pend_new;
    logic m_wait;
    logic m_ready;
    logic m_rr;
    logic e_tick[2];
    logic e_out[2];
    logic e_err;
    smp_t sb[$];
    vec_t vecs[16];

    task automatic chk(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0b want=%0b", name, cyc, act, exp);
        end
    endtask

    task automatic model_init();
        cyc        = 0;
        m_per[0]   = 25;
        m_per[1]   = 50;
        for (int ch = 0; ch < 2; ch++) begin
            m_last[ch] = 0;
            m_next[ch] = m_per[ch];
        end
        m_pend_new = 1'b0;
        m_wait     = 1'b0;
        m_ready    = 1'b0;
        m_rr       = 1'b0;
        m_new_per  = 0;
        m_new_sel  = 0;
        m_acc_edge = 0;
        sb.delete();
    endtask

    // One clock: advance the model on the edge, compare every output at the falling edge
    task automatic step();
        logic exp_v;
        logic exp_s;
        @(posedge in_clock);
        cyc++;
        e_err = 1'b0;
        if (m_ready && cfg_valid) begin
            if (cfg_div < CNT_W'(2)) begin
                e_err = 1'b1;
            end else begin
                m_pend_new = 1'b1;
                m_new_sel  = cfg_sel ? 1 : 0;
                m_new_per  = int'(cfg_div);
                m_acc_edge = cyc;
                m_wait     = 1'b1;
            end
        end
        for (int ch = 0; ch < 2; ch++) begin
            e_out[ch]  = (cyc - m_last[ch] - 1) < (m_per[ch] / 2);
            e_tick[ch] = (cyc == m_next[ch]);
            if (e_tick[ch]) begin
                m_last[ch] = cyc;
                if (m_pend_new && m_new_sel == ch && cyc > m_acc_edge) begin
                    m_per[ch]  = m_new_per;
                    m_pend_new = 1'b0;
                    m_wait     = 1'b0;
                end
                m_next[ch] = cyc + m_per[ch];
            end
        end
        m_ready = !m_wait;
        if (e_tick[0] && e_tick[1]) begin
            sb.push_back('{cyc + 1, m_rr});
            sb.push_back('{cyc + 2, !m_rr});
            m_rr = !m_rr;
        end else if (e_tick[0]) begin
            sb.push_back('{cyc + 1, 1'b0});
        end else if (e_tick[1]) begin
            sb.push_back('{cyc + 1, 1'b1});
        end
        @(negedge in_clock);
        exp_v = 1'b0;
        exp_s = 1'b0;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            exp_v = 1'b1;
            exp_s = sb[0].sel;
            sb.delete(0);
        end
        chk("tick_GLONASS", tick_GLONASS, e_tick[0]);
        chk("tick_GPS", tick_GPS, e_tick[1]);
        chk("out_clock_GLONASS", out_clock_GLONASS, e_out[0]);
        chk("out_clock_GPS", out_clock_GPS, e_out[1]);
        chk("smp_valid", smp_valid, exp_v);
        if (exp_v) chk("smp_sel", smp_sel, exp_s);
        chk("cfg_ready", cfg_ready, m_ready);
        chk("cfg_err", cfg_err, e_err);
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic request(input logic sel, input int div);
        cfg_valid = 1'b1;
        cfg_sel   = sel;
        cfg_div   = CNT_W'(div);
        step();
        cfg_valid = 1'b0;
        cfg_div   = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tick_GLONASS"}, tick_GLONASS, 1'b0);
        chk({tag, "_tick_GPS"}, tick_GPS, 1'b0);
        chk({tag, "_out_GLONASS"}, out_clock_GLONASS, 1'b0);
        chk({tag, "_out_GPS"}, out_clock_GPS, 1'b0);
        chk({tag, "_smp_valid"}, smp_valid, 1'b0);
        chk({tag, "_smp_sel"}, smp_sel, 1'b0);
        chk({tag, "_cfg_ready"}, cfg_ready, 1'b0);
        chk({tag, "_cfg_err"}, cfg_err, 1'b0);
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_sel   = 1'b0;
        cfg_div   = '0;
        model_init();

        vecs = '{
            '{1,   6'b001100}, '{12,  6'b001100}, '{13,  6'b000100}, '{25,  6'b100100},
            '{26,  6'b001010}, '{27,  6'b001000}, '{50,  6'b110000}, '{51,  6'b001110},
            '{52,  6'b001111}, '{53,  6'b001100}, '{75,  6'b100100}, '{76,  6'b001010},
            '{100, 6'b110000}, '{101, 6'b001111}, '{102, 6'b001110}, '{103, 6'b001100}
        };

        repeat (2) @(negedge in_clock);
        chk_all_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_to(vecs[i].cyc);
            chk("vec_tick_GLONASS", tick_GLONASS, vecs[i].exp[5]);
            chk("vec_tick_GPS", tick_GPS, vecs[i].exp[4]);
            chk("vec_out_GLONASS", out_clock_GLONASS, vecs[i].exp[3]);
            chk("vec_out_GPS", out_clock_GPS, vecs[i].exp[2]);
            chk("vec_smp_valid", smp_valid, vecs[i].exp[1]);
            chk("vec_smp_sel", smp_valid & smp_sel, vecs[i].exp[0]);
        end

        // GPS -> 10 mid-period: old 50-cycle period finishes at 150
        run_to(110);
        request(1'b1, 10);
        chk("gps_acc_ready", cfg_ready, 1'b0);
        run_to(150);
        chk("gps_old_wrap", tick_GPS, 1'b1);
        chk("gps_ready_back", cfg_ready, 1'b1);
        run_to(155);
        chk("gps_new_high", out_clock_GPS, 1'b1);
        run_to(156);
        chk("gps_new_low", out_clock_GPS, 1'b0);
        run_to(160);
        chk("gps_new_tick", tick_GPS, 1'b1);

        // Rejected divisor
        run_to(179);
        request(1'b0, 1);
        chk("rej_err", cfg_err, 1'b1);
        chk("rej_ready", cfg_ready, 1'b1);
        step();
        chk("rej_err_clear", cfg_err, 1'b0);

        // Request lands in the GLONASS wrap cycle: one more full 25-cycle period
        run_to(199);
        request(1'b0, 8);
        chk("wrapcyc_tick", tick_GLONASS, 1'b1);
        chk("wrapcyc_ready", cfg_ready, 1'b0);
        run_to(208);
        chk("wrapcyc_no_early", tick_GLONASS, 1'b0);
        run_to(225);
        chk("wrapcyc_old_period", tick_GLONASS, 1'b1);
        chk("wrapcyc_ready_back", cfg_ready, 1'b1);
        run_to(233);
        chk("wrapcyc_new_period", tick_GLONASS, 1'b1);

        // Reset while waiting for the GPS wrap
        run_to(244);
        request(1'b1, 30);
        step();
        chk("rstwait_ready", cfg_ready, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("rstwait");
        repeat (3) @(posedge in_clock);
        @(negedge in_clock);
        reset = 1'b0;
        model_init();
        run_to(30);
        chk("rstwait_no_div30", tick_GPS, 1'b0);
        run_to(50);
        chk("rstwait_init_gps", tick_GPS, 1'b1);
        chk("rstwait_init_glo", tick_GLONASS, 1'b1);
        run_to(110);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
